// File: rtl/lru_matrix_arbiter_hs_if.sv
// Request/grant handshake bundle for lru_matrix_arbiter_hs.
// req_mask is present only when ARB_REQ_MASK_EN is defined.
interface lru_matrix_arbiter_hs_if #(
  parameter int unsigned NUM_REQ = 10
) ();
  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] lock;
`ifdef ARB_REQ_MASK_EN
  logic [NUM_REQ-1:0] req_mask;
`endif
  logic               gnt_ready;
  logic               gnt_valid;
  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               lock_active;

`ifdef ARB_REQ_MASK_EN
  modport master (output req, lock, req_mask, gnt_ready,
                  input  gnt_valid, gnt, gnt_idx, lock_active);
  modport slave  (input  req, lock, req_mask, gnt_ready,
                  output gnt_valid, gnt, gnt_idx, lock_active);
`else
  modport master (output req, lock, gnt_ready,
                  input  gnt_valid, gnt, gnt_idx, lock_active);
  modport slave  (input  req, lock, gnt_ready,
                  output gnt_valid, gnt, gnt_idx, lock_active);
`endif
endinterface

// File: rtl/lru_matrix_arbiter_hs.sv
// LRU matrix arbiter with registered one-hot grant, valid/ready handshake and bounded lock.
// Optional requester masking is enabled by defining ARB_REQ_MASK_EN.
module lru_matrix_arbiter_hs #(
  parameter int unsigned NUM_REQ  = 10,
  parameter int unsigned MAX_LOCK = 16
) (
  input  logic                   clk,
  input  logic                   rst_b,
  lru_matrix_arbiter_hs_if.slave arb
);
  localparam int unsigned IDX_W   = $clog2(NUM_REQ);
  localparam int unsigned PAIRS   = NUM_REQ * (NUM_REQ - 1) / 2;
  localparam int unsigned CNT_W   = $clog2(MAX_LOCK + 1);
  localparam bit          LOCK_EN = (MAX_LOCK > 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_LOCK  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [PAIRS-1:0]   pri_q, pri_d, pri_acc;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               gnt_valid_q, gnt_valid_d;
  logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
  logic               lock_active_q, lock_active_d;
  logic [CNT_W-1:0]   lock_cnt_q, lock_cnt_d, lock_cnt_inc;

  logic [NUM_REQ-1:0] elig, win_cur, win_acc;
  logic               accept, g_elig, lock_enter, lock_done;

`ifdef ARB_REQ_MASK_EN
  assign elig = arb.req & ~arb.req_mask;
`else
  assign elig = arb.req;
`endif

  // Priority after accepting the held grant: it loses to everybody.
  for (genvar i = 1; i < NUM_REQ; i++) begin : g_pri_hi
    for (genvar j = 0; j < i; j++) begin : g_pri_lo
      assign pri_acc[i*(i-1)/2 + j] = gnt_q[j] | (pri_q[i*(i-1)/2 + j] & ~gnt_q[i]);
    end
  end

  // Winner against the stored and the post-accept priority; only i>j bits are stored.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_win
    logic [NUM_REQ-1:0] beaten_cur, beaten_acc;
    for (genvar j = 0; j < NUM_REQ; j++) begin : g_col
      if (j > i) begin : g_above
        assign beaten_cur[j] = pri_q[j*(j-1)/2 + i];
        assign beaten_acc[j] = pri_acc[j*(j-1)/2 + i];
      end else if (j < i) begin : g_below
        assign beaten_cur[j] = ~pri_q[i*(i-1)/2 + j];
        assign beaten_acc[j] = ~pri_acc[i*(i-1)/2 + j];
      end else begin : g_diag
        assign beaten_cur[j] = 1'b0;
        assign beaten_acc[j] = 1'b0;
      end
    end
    assign win_cur[i] = elig[i] & ~|(elig & beaten_cur);
    assign win_acc[i] = elig[i] & ~|(elig & beaten_acc);
  end

  function automatic logic [IDX_W-1:0] onehot_idx(input logic [NUM_REQ-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (oh[k]) idx = IDX_W'(k);
    end
    return idx;
  endfunction

  assign accept       = gnt_valid_q & arb.gnt_ready;
  assign g_elig       = |(elig & gnt_q);
  assign lock_enter   = LOCK_EN & |(arb.lock & arb.req & gnt_q);
  assign lock_cnt_inc = lock_cnt_q + CNT_W'(1);
  assign lock_done    = ~|(arb.lock & gnt_q) | (lock_cnt_inc == CNT_W'(MAX_LOCK));

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Accept is evaluated before withdraw: a beat already taken cannot be undone.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (|elig) state_d = S_GRANT;
      end
      S_GRANT: begin
        if (accept) begin
          if (lock_enter) state_d = S_LOCK;
          else            state_d = (|elig) ? S_GRANT : S_IDLE;
        end else if (!g_elig) begin
          state_d = S_IDLE;
        end
      end
      S_LOCK: begin
        if (accept) begin
          if (lock_done) state_d = (|elig) ? S_GRANT : S_IDLE;
        end else if (!g_elig) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pri_d         = pri_q;
    gnt_d         = gnt_q;
    gnt_valid_d   = gnt_valid_q;
    gnt_idx_d     = gnt_idx_q;
    lock_active_d = lock_active_q;
    lock_cnt_d    = lock_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (|elig) begin
          gnt_d       = win_cur;
          gnt_valid_d = 1'b1;
          gnt_idx_d   = onehot_idx(win_cur);
        end
      end
      S_GRANT: begin
        if (accept) begin
          pri_d = pri_acc;
          if (lock_enter) begin
            lock_cnt_d    = CNT_W'(1);
            lock_active_d = 1'b1;
          end else begin
            gnt_d       = win_acc;
            gnt_valid_d = |elig;
            gnt_idx_d   = onehot_idx(win_acc);
          end
        end else if (!g_elig) begin
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          gnt_idx_d   = '0;
        end
      end
      S_LOCK: begin
        // Priority was already demoted on the first beat of the sequence.
        if (accept) begin
          if (lock_done) begin
            lock_cnt_d    = '0;
            lock_active_d = 1'b0;
            gnt_d         = win_cur;
            gnt_valid_d   = |elig;
            gnt_idx_d     = onehot_idx(win_cur);
          end else begin
            lock_cnt_d = lock_cnt_inc;
          end
        end else if (!g_elig) begin
          gnt_d         = '0;
          gnt_valid_d   = 1'b0;
          gnt_idx_d     = '0;
          lock_cnt_d    = '0;
          lock_active_d = 1'b0;
        end
      end
      default: begin
        gnt_d         = '0;
        gnt_valid_d   = 1'b0;
        gnt_idx_d     = '0;
        lock_cnt_d    = '0;
        lock_active_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      pri_q         <= '1;
      gnt_q         <= '0;
      gnt_valid_q   <= 1'b0;
      gnt_idx_q     <= '0;
      lock_active_q <= 1'b0;
      lock_cnt_q    <= '0;
    end else begin
      pri_q         <= pri_d;
      gnt_q         <= gnt_d;
      gnt_valid_q   <= gnt_valid_d;
      gnt_idx_q     <= gnt_idx_d;
      lock_active_q <= lock_active_d;
      lock_cnt_q    <= lock_cnt_d;
    end
  end

  assign arb.gnt         = gnt_q;
  assign arb.gnt_valid   = gnt_valid_q;
  assign arb.gnt_idx     = gnt_idx_q;
  assign arb.lock_active = lock_active_q;

endmodule
